button_event_detect: RTL

//  Consumes the two-flop-synchronised button level and turns it into clean user events.

---
 rtl/button_event_detect.sv | 126 ++++++++++++
 1 files changed

// File: rtl/button_event_detect.sv
// Debounces a synchronised button level and classifies each press into
// press/release/short/long/auto-repeat single-cycle pulses.
module button_event_detect #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sync,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {IDLE, DB_DN, HELD, LONG, DB_UP} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_nxt, hold_cnt, hold_nxt;
  logic             long_flag, long_nxt, level_nxt;
  logic             press_nxt, release_nxt, short_nxt, longp_nxt, repeat_nxt;

  // Counters stick at all-ones rather than wrapping back to a matching value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt   = state;
    deb_nxt     = deb_cnt;
    hold_nxt    = hold_cnt;
    long_nxt    = long_flag;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    short_nxt   = 1'b0;
    longp_nxt   = 1'b0;
    repeat_nxt  = 1'b0;
    case (state)
      IDLE: if (btn_sync) begin
        state_nxt = DB_DN;
        deb_nxt   = CNT_W'(1);
      end
      DB_DN: begin
        if (!btn_sync) state_nxt = IDLE;
        else if (deb_cnt == DEB_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
          level_nxt = 1'b1;
          hold_nxt  = '0;
          long_nxt  = 1'b0;
        end else deb_nxt = sat_inc(deb_cnt);
      end
      // A drop on the completing edge goes to DB_UP: release wins over long/repeat.
      HELD: begin
        if (!btn_sync) begin
          state_nxt = DB_UP;
          deb_nxt   = CNT_W'(1);
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt = LONG;
          longp_nxt = 1'b1;
          long_nxt  = 1'b1;
          hold_nxt  = '0;
        end else hold_nxt = sat_inc(hold_cnt);
      end
      LONG: begin
        if (!btn_sync) begin
          state_nxt = DB_UP;
          deb_nxt   = CNT_W'(1);
        end else if (REPEAT_EN) begin
          if (hold_cnt == REP_LAST) begin
            repeat_nxt = 1'b1;
            hold_nxt   = '0;
          end else hold_nxt = sat_inc(hold_cnt);
        end
      end
      // hold_cnt stays frozen so a bounce resumes the hold where it left off.
      DB_UP: begin
        if (btn_sync) state_nxt = long_flag ? LONG : HELD;
        else if (deb_cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          short_nxt   = !long_flag;
          level_nxt   = 1'b0;
        end else deb_nxt = sat_inc(deb_cnt);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      long_flag     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_nxt;
      deb_cnt       <= deb_nxt;
      hold_cnt      <= hold_nxt;
      long_flag     <= long_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      short_press   <= short_nxt;
      long_press    <= longp_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

endmodule
